// File: rtl/led_flash_sequencer.sv
// Timed ON/OFF LED flash engine with ALL, CHASE and SINGLE patterns and a repetition count.
// Optional abort input enabled by defining LED_FLASH_ABORT_EN.
module led_flash_sequencer #(
  parameter int unsigned NUM_LEDS   = 4,
  parameter int unsigned CLOCK_FREQ = 50000000,
  parameter int unsigned ON_TICKS   = CLOCK_FREQ,
  parameter int unsigned OFF_TICKS  = 5 * CLOCK_FREQ,
  parameter int unsigned CNT_W      = 32
) (
  input  logic                        i_clock,
  input  logic                        i_reset,
  input  logic                        i_start,
  input  logic [1:0]                  i_mode,
  input  logic [$clog2(NUM_LEDS)-1:0] i_led_sel,
  input  logic [3:0]                  i_reps,
`ifdef LED_FLASH_ABORT_EN
  input  logic                        i_abort,
`endif
  output logic [NUM_LEDS-1:0]         o_leds,
  output logic                        o_busy,
  output logic                        o_done
);

  localparam int unsigned SelW = $clog2(NUM_LEDS);
  localparam int unsigned FlW  = $clog2(15 * NUM_LEDS + 1);

  typedef enum logic [1:0] {StIdle, StOn, StOff, StDone} state_e;

  state_e              r_state, w_state_d;
  logic [CNT_W-1:0]    r_cnt, w_cnt_d;
  logic [FlW-1:0]      r_flash, w_flash_d;
  logic [FlW-1:0]      r_total, w_total_d;
  logic [SelW-1:0]     r_idx, w_idx_d;
  logic [SelW-1:0]     r_sel, w_sel_d;
  logic [1:0]          r_mode, w_mode_d;
  logic [NUM_LEDS-1:0] r_leds, w_leds_d;
  logic                r_busy, w_busy_d;
  logic                r_done, w_done_d;

  logic                w_abort;
  logic [3:0]          w_reps_eff;
  logic [NUM_LEDS-1:0] w_onehot_one;
  logic [NUM_LEDS-1:0] w_pat;

`ifdef LED_FLASH_ABORT_EN
  assign w_abort = i_abort;
`else
  assign w_abort = 1'b0;
`endif

  assign w_reps_eff   = (i_reps == 4'd0) ? 4'd1 : i_reps;
  assign w_onehot_one = {{(NUM_LEDS-1){1'b0}}, 1'b1};

  always_comb begin
    w_state_d = r_state;
    w_cnt_d   = r_cnt;
    w_flash_d = r_flash;
    w_total_d = r_total;
    w_idx_d   = r_idx;
    w_sel_d   = r_sel;
    w_mode_d  = r_mode;
    unique case (r_state)
      StIdle: begin
        if (i_start) begin
          w_state_d = StOn;
          w_cnt_d   = '0;
          w_flash_d = '0;
          w_idx_d   = '0;
          w_mode_d  = i_mode;
          w_sel_d   = i_led_sel;
          // CHASE runs full sweeps, so each repetition covers every LED once
          w_total_d = (i_mode == 2'b01) ? FlW'(w_reps_eff * NUM_LEDS) : FlW'(w_reps_eff);
        end
      end
      StOn: begin
        if (w_abort) begin
          w_state_d = StDone;
        end else if (r_cnt == CNT_W'(ON_TICKS - 1)) begin
          w_state_d = StOff;
          w_cnt_d   = '0;
        end else begin
          w_cnt_d = r_cnt + CNT_W'(1);
        end
      end
      StOff: begin
        if (w_abort) begin
          w_state_d = StDone;
        end else if (r_cnt == CNT_W'(OFF_TICKS - 1)) begin
          w_cnt_d = '0;
          if (r_flash == r_total - FlW'(1)) begin
            w_state_d = StDone;
          end else begin
            w_state_d = StOn;
            w_flash_d = r_flash + FlW'(1);
            w_idx_d   = (r_idx == SelW'(NUM_LEDS - 1)) ? '0 : r_idx + SelW'(1);
          end
        end else begin
          w_cnt_d = r_cnt + CNT_W'(1);
        end
      end
      StDone: begin
        w_state_d = StIdle;
      end
      default: begin
        w_state_d = StIdle;
      end
    endcase

    // Pattern uses next-state values so the registered LEDs line up with the ON state
    unique case (w_mode_d)
      2'b01:   w_pat = w_onehot_one << w_idx_d;
      2'b10:   w_pat = w_onehot_one << w_sel_d;
      default: w_pat = '1;
    endcase
    w_leds_d = (w_state_d == StOn) ? w_pat : '0;
    w_busy_d = (w_state_d == StOn) || (w_state_d == StOff);
    w_done_d = (w_state_d == StDone);
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_state <= StIdle;
      r_cnt   <= '0;
      r_flash <= '0;
      r_total <= '0;
      r_idx   <= '0;
      r_sel   <= '0;
      r_mode  <= '0;
      r_leds  <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_cnt   <= w_cnt_d;
      r_flash <= w_flash_d;
      r_total <= w_total_d;
      r_idx   <= w_idx_d;
      r_sel   <= w_sel_d;
      r_mode  <= w_mode_d;
      r_leds  <= w_leds_d;
      r_busy  <= w_busy_d;
      r_done  <= w_done_d;
    end
  end

  assign o_leds = r_leds;
  assign o_busy = r_busy;
  assign o_done = r_done;

endmodule

// File: tb/tb_led_flash_sequencer.sv
// Bench for led_flash_sequencer: directed cases plus randomized runs against a trace model.
// Define LED_FLASH_ABORT_EN to also exercise the abort input.
module tb_led_flash_sequencer;

  localparam int unsigned NL  = 4;
  localparam int unsigned ONT = 4;
  localparam int unsigned OFT = 6;

  logic          clk;
  logic          rst;
  logic          start;
  logic [1:0]    mode;
  logic [1:0]    led_sel;
  logic [3:0]    reps;
`ifdef LED_FLASH_ABORT_EN
  logic          abort;
`endif
  logic [NL-1:0] leds;
  logic          busy;
  logic          done;

  int n_vec  = 0;
  int n_miss = 0;

  led_flash_sequencer #(
    .NUM_LEDS  (NL),
    .CLOCK_FREQ(10),
    .ON_TICKS  (ONT),
    .OFF_TICKS (OFT),
    .CNT_W     (8)
  ) dut (
    .i_clock  (clk),
    .i_reset  (rst),
    .i_start  (start),
    .i_mode   (mode),
    .i_led_sel(led_sel),
    .i_reps   (reps),
`ifdef LED_FLASH_ABORT_EN
    .i_abort  (abort),
`endif
    .o_leds   (leds),
    .o_busy   (busy),
    .o_done   (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Observed vector is {leds, busy, done}
  task automatic check(input string tag, input logic [5:0] expv);
    logic [5:0] obs;
    obs = {leds, busy, done};
    n_vec++;
    assert (obs === expv) else begin
      n_miss++;
      $error("FAIL %s t=%0t observed=%b required=%b", tag, $time, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] model_pat(input logic [1:0] m, input logic [1:0] s, input int f);
    if (m == 2'b01) return 4'(1 << (f % NL));
    if (m == 2'b10) return 4'(1 << s);
    return 4'hF;
  endfunction

  // Full sequence from start: junk=1 scribbles on start/mode/sel/reps during the run
  task automatic run_seq(input string tag, input logic [1:0] m, input logic [1:0] s,
                         input logic [3:0] r, input bit junk);
    logic [5:0] trace[$];
    int flashes;
    flashes = (r == 0) ? 1 : int'(r);
    if (m == 2'b01) flashes = flashes * NL;
    for (int f = 0; f < flashes; f++) begin
      for (int k = 0; k < int'(ONT); k++) trace.push_back({model_pat(m, s, f), 2'b10});
      for (int k = 0; k < int'(OFT); k++) trace.push_back({4'h0, 2'b10});
    end
    trace.push_back({4'h0, 2'b01});
    start = 1'b1; mode = m; led_sel = s; reps = r;
    for (int i = 0; i < trace.size(); i++) begin
      tick();
      if (i == 0) start = 1'b0;
      check(tag, trace[i]);
      if (junk && i != trace.size() - 1) begin
        start   = 1'($urandom);
        mode    = 2'($urandom);
        led_sel = 2'($urandom);
        reps    = 4'($urandom);
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    tick();
    check({tag, "_idle"}, 6'b0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; mode = 2'b00; led_sel = 2'b00; reps = 4'd0;
`ifdef LED_FLASH_ABORT_EN
    abort = 1'b0;
`endif
    tick();
    tick();
    check("reset", 6'b0);
    rst = 1'b0;

    for (int i = 0; i < 50; i++) begin
      mode = 2'($urandom); led_sel = 2'($urandom); reps = 4'($urandom);
      tick();
      check("idle50", 6'b0);
    end

    run_seq("all_r2", 2'b00, 2'd0, 4'd2, 1'b0);
    run_seq("chase_r1", 2'b01, 2'd0, 4'd1, 1'b0);
    run_seq("single_s2_r0", 2'b10, 2'd2, 4'd0, 1'b1);
    run_seq("resv_r1", 2'b11, 2'd1, 4'd1, 1'b1);

    // Reset in the middle of an ALL run clears outputs asynchronously
    start = 1'b1; mode = 2'b00; reps = 4'd2;
    tick();
    start = 1'b0;
    check("rst_c1", {4'hF, 2'b10});
    for (int i = 2; i <= 7; i++) tick();
    check("rst_c7", {4'h0, 2'b10});
    rst = 1'b1;
    #1;
    check("rst_async", 6'b0);
    tick();
    tick();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("rst_after", 6'b0);
    end
    run_seq("post_rst", 2'b00, 2'd0, 4'd1, 1'b0);

`ifdef LED_FLASH_ABORT_EN
    start = 1'b1; mode = 2'b00; reps = 4'd3;
    tick();
    start = 1'b0;
    check("abort_c1", {4'hF, 2'b10});
    tick();
    check("abort_c2", {4'hF, 2'b10});
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_c3", {4'h0, 2'b01});
    tick();
    check("abort_c4", 6'b0);
    abort = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("abort_idle", 6'b0);
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    check("abort_start_wins", {4'hF, 2'b10});
    tick();
    abort = 1'b0;
    check("abort_next", {4'h0, 2'b01});
    tick();
    check("abort_back_idle", 6'b0);
`endif

    for (int n = 0; n < 10; n++) begin
      run_seq("rand", 2'($urandom), 2'($urandom), 4'($urandom_range(0, 6)), 1'($urandom));
      for (int k = 0; k < int'($urandom_range(0, 3)); k++) begin
        tick();
        check("rand_gap", 6'b0);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
